// File: rtl/display_scan.sv
// display_scan
//   Walks display slots 1..NUM_ENTRIES once per frame. For each slot it puts
//   the slot number on display_number, waits for the provider's registered
//   response, captures it and, when the slot holds content, presents it to a
//   downstream renderer with a valid/ready handshake. Between frames it waits
//   FRAME_GAP cycles after the cycle that carries frame_done.
//
//   Optional feature (macro DISPLAY_SCAN_CHANGE_ONLY_EN): per-slot shadow
//   copies of the last response; a valid slot is presented only if it was
//   invalid last frame or its name/value changed.
//
// Ports
//   clk             clock
//   reset           asynchronous, active-high reset
//   scan_en         level; allows a new frame to start (sampled in IDLE only)
//   display_number  slot requested from the provider (0 = no request)
//   display_valid   provider: slot holds content
//   display_name    provider: 5 ASCII chars, first char in the MSBs
//   display_value   provider: 32-bit value
//   out_valid       entry presented on out_*
//   out_ready       renderer accepts the entry
//   out_index       slot number of the presented entry
//   out_name        captured name
//   out_value       captured value
//   frame_done      one-cycle pulse after the last slot is processed
//
// State  | meaning
// IDLE   | no request; waits for scan_en
// ADDR   | slot on display_number, provider registering it
// SETTLE | provider response valid; captured at exit edge
// EMIT   | entry presented until out_ready
// GAP    | frame_done cycle followed by FRAME_GAP idle cycles

module display_scan #(
  parameter int NUM_ENTRIES = 44,
  parameter int FRAME_GAP   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_en,
  output logic [5:0]  display_number,
  input  logic        display_valid,
  input  logic [39:0] display_name,
  input  logic [31:0] display_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_index,
  output logic [39:0] out_name,
  output logic [31:0] out_value,
  output logic        frame_done
);

  localparam logic [5:0] LAST_SLOT = 6'(NUM_ENTRIES);
  localparam logic [7:0] GAP_LOAD  = 8'(FRAME_GAP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_SETTLE,
    S_EMIT,
    S_GAP
  } state_t;

  state_t     state, state_nxt;
  logic [5:0] slot, slot_nxt;
  logic [7:0] gap_cnt, gap_cnt_nxt;
  logic       done_nxt;
  logic       advance;
  logic       emit_ok;
  logic       capture;

  // The provider response for the current slot is valid only during SETTLE.
  assign capture = (state == S_SETTLE);

`ifdef DISPLAY_SCAN_CHANGE_ONLY_EN
  // Indexed directly by the 6-bit slot; entries above NUM_ENTRIES are never
  // written and reduce to constants.
  logic        sh_valid [64];
  logic [39:0] sh_name  [64];
  logic [31:0] sh_value [64];

  assign emit_ok = display_valid &&
                   (!sh_valid[slot] ||
                    (sh_name[slot]  != display_name) ||
                    (sh_value[slot] != display_value));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        sh_valid[i] <= 1'b0;
        sh_name[i]  <= '0;
        sh_value[i] <= '0;
      end
    end else if (capture) begin
      sh_valid[slot] <= display_valid;
      sh_name[slot]  <= display_name;
      sh_value[slot] <= display_value;
    end
  end
`else
  assign emit_ok = display_valid;
`endif

  always_comb begin
    state_nxt   = state;
    slot_nxt    = slot;
    gap_cnt_nxt = gap_cnt;
    done_nxt    = 1'b0;
    advance     = 1'b0;
    case (state)
      S_IDLE: begin
        if (scan_en) begin
          slot_nxt  = 6'd1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR:   state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (emit_ok) state_nxt = S_EMIT;
        else         advance   = 1'b1;
      end
      S_EMIT: begin
        if (out_ready) advance = 1'b1;
      end
      S_GAP: begin
        // Down-counter loaded with FRAME_GAP on frame end; the first GAP
        // cycle carries frame_done, then FRAME_GAP further cycles follow.
        if (gap_cnt == 8'd0) state_nxt   = S_IDLE;
        else                 gap_cnt_nxt = gap_cnt - 8'd1;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (advance) begin
      if (slot < LAST_SLOT) begin
        slot_nxt  = slot + 6'd1;
        state_nxt = S_ADDR;
      end else begin
        done_nxt    = 1'b1;
        gap_cnt_nxt = GAP_LOAD;
        state_nxt   = S_GAP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      slot       <= 6'd0;
      gap_cnt    <= 8'd0;
      frame_done <= 1'b0;
      out_index  <= 6'd0;
      out_name   <= '0;
      out_value  <= '0;
    end else begin
      state      <= state_nxt;
      slot       <= slot_nxt;
      gap_cnt    <= gap_cnt_nxt;
      frame_done <= done_nxt;
      if (capture) begin
        out_index <= slot;
        out_name  <= display_name;
        out_value <= display_value;
      end
    end
  end

  // Decoded from state so reset clears them without waiting for a clock.
  assign display_number = (state == S_ADDR || state == S_SETTLE) ? slot : 6'd0;
  assign out_valid      = (state == S_EMIT);

endmodule

// File: tb/tb_display_scan.sv
module tb_display_scan;

  localparam int N   = 44;
  localparam int GAP = 16;

  logic        clk;
  logic        reset;
  logic        scan_en;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_index;
  logic [39:0] out_name;
  logic [31:0] out_value;
  logic        frame_done;

  display_scan #(.NUM_ENTRIES(N), .FRAME_GAP(GAP)) dut (
    .clk(clk),
    .reset(reset),
    .scan_en(scan_en),
    .display_number(display_number),
    .display_valid(display_valid),
    .display_name(display_name),
    .display_value(display_value),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_name(out_name),
    .out_value(out_value),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // provider content and its one-register response path
  logic        pv   [64];
  logic [39:0] pn   [64];
  logic [31:0] pval [64];

  always @(posedge clk) begin
    display_valid <= (display_number != 6'd0) && pv[display_number];
    display_name  <= pn[display_number];
    display_value <= pval[display_number];
  end

  // reference model: expected entries of the pending frame, in order
  typedef struct {
    logic [5:0]  idx;
    logic [39:0] name;
    logic [31:0] val;
  } ent_t;

  ent_t q[$];
  int   cur_v = 0;
  int   mode = 0;
  int   frames = 0;
  int   cyc = 0;
  int   last_fd = 0;
  bit   last_fd_valid = 0;
  bit   ready_dropped = 0;
  bit   stall_prev = 0;
  logic [5:0]  p_idx;
  logic [39:0] p_name;
  logic [31:0] p_val;

`ifdef DISPLAY_SCAN_CHANGE_ONLY_EN
  logic        mv   [64];
  logic [39:0] mn   [64];
  logic [31:0] mval [64];
`endif

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [39:0] std_name(input int s);
    return {8'h53, 8'h4C, 8'h54, 8'(8'h30 + s / 10), 8'(8'h30 + s % 10)};
  endfunction

  task automatic set_content(input int m);
    logic [63:0] r;
    logic [39:0] wdata;
    wdata = "WDATA";
    for (int s = 0; s < 64; s++) begin
      case (m)
        0, 1: begin
          pv[s]   = (s == 1 || s == 2 || s == 3 || s == 5 || s == 6);
          pn[s]   = std_name(s);
          pval[s] = 32'(s * 32'h11);
          if (m == 1 && s == 2) begin
            pn[s]   = wdata;
            pval[s] = 32'h1234_5678;
          end
        end
        2: begin
          if (s >= 1 && s <= N && $urandom_range(0, 3) == 0) begin
            r       = {$urandom, $urandom};
            pv[s]   = ($urandom_range(0, 1) == 1);
            pn[s]   = r[39:0];
            pval[s] = $urandom;
          end
        end
        default: pv[s] = 1'b0;
      endcase
    end
    pv[0] = 1'b0;
  endtask

  task automatic model_reset();
`ifdef DISPLAY_SCAN_CHANGE_ONLY_EN
    for (int s = 0; s < 64; s++) begin
      mv[s]   = 1'b0;
      mn[s]   = '0;
      mval[s] = '0;
    end
`endif
    q.delete();
  endtask

  task automatic build_frame();
    ent_t e;
    bit   emit;
    cur_v = 0;
    for (int s = 1; s <= N; s++) begin
      emit = pv[s];
`ifdef DISPLAY_SCAN_CHANGE_ONLY_EN
      if (pv[s] && mv[s] && mn[s] == pn[s] && mval[s] == pval[s]) emit = 0;
      mv[s]   = pv[s];
      mn[s]   = pn[s];
      mval[s] = pval[s];
`endif
      if (emit) begin
        e.idx  = 6'(s);
        e.name = pn[s];
        e.val  = pval[s];
        q.push_back(e);
        cur_v++;
      end
    end
  endtask

  // monitor / scoreboard, sampling on the falling edge
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        cyc++;
        if (!out_ready) ready_dropped = 1;
        if (stall_prev) begin
          check("stall_valid", out_valid, 1'b1);
          check("stall_index", out_index, p_idx);
          check("stall_name", out_name, p_name);
          check("stall_value", out_value, p_val);
        end
        if (out_valid && q.size() == 0) begin
          check("unexpected_valid", out_valid, 1'b0);
        end else if (out_valid && out_ready) begin
          e = q.pop_front();
          check("entry_index", out_index, e.idx);
          check("entry_name", out_name, e.name);
          check("entry_value", out_value, e.val);
        end
        stall_prev = out_valid && !out_ready;
        p_idx  = out_index;
        p_name = out_name;
        p_val  = out_value;
        if (frame_done) begin
          check("frame_left", q.size(), 0);
          if (last_fd_valid && !ready_dropped)
            check("frame_period", cyc - last_fd, GAP + 1 + 2 * N + cur_v + 1);
          last_fd       = cyc;
          last_fd_valid = 1;
          ready_dropped = 0;
          frames++;
          set_content(mode);
          build_frame();
        end
      end
    end
  end

  task automatic wait_frames(input int n);
    int target;
    target = frames + n;
    for (int i = 0; i < n * 400 && frames < target; i++) @(negedge clk);
    check("wait_frames", frames, target);
  endtask

  initial begin
    bit found;
    logic [39:0] wdata;
    wdata = "WDATA";
    reset     = 1'b1;
    scan_en   = 1'b0;
    out_ready = 1'b1;
    mode      = 0;
    set_content(0);
    model_reset();
    build_frame();

    #1;
    check("rst_display_number", display_number, 6'd0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_index", out_index, 6'd0);
    check("rst_out_name", out_name, 40'd0);
    check("rst_out_value", out_value, 32'd0);
    check("rst_frame_done", frame_done, 1'b0);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // scan_en low: stays idle
    repeat (5) begin
      @(negedge clk);
      check("idle_display_number", display_number, 6'd0);
      check("idle_out_valid", out_valid, 1'b0);
    end
    @(posedge clk);
    #1 scan_en = 1'b1;

    // reset while slot 5 is presented
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_index == 6'd5) found = 1;
    end
    check("wait_slot5", found, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_display_number", display_number, 6'd0);
    check("abort_frame_done", frame_done, 1'b0);
    model_reset();
    build_frame();
    last_fd_valid = 0;
    stall_prev    = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    wait_frames(3);

    // 10-cycle stall on slot 2
    mode = 1;
    wait_frames(1);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (display_number == 6'd2) found = 1;
    end
    check("wait_slot2", found, 1'b1);
    @(posedge clk);
    #1 out_ready = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1;
    end
    check("stall_emit", found, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      check("hold_valid", out_valid, 1'b1);
      check("hold_index", out_index, 6'd2);
      check("hold_name", out_name, wdata);
      check("hold_value", out_value, 32'h1234_5678);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("after_accept_number", display_number, 6'd3);
    check("after_accept_valid", out_valid, 1'b0);

    // all-invalid frames
    mode = 3;
    wait_frames(4);

    // randomized content and back-pressure
    mode = 2;
    begin
      int target;
      target = frames + 12;
      for (int i = 0; i < 12 * 600 && frames < target; i++) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
      check("random_frames", frames, target);
    end
    out_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
Parameters (name, default, meaning):
REQ-001 NUM_ENTRIES, 44, highest display number scanned; numbers 1..NUM_ENTRIES; legal range 1..63.
REQ-002 FRAME_GAP, 16, idle cycles between end of one frame and start of the next; legal range 0..255.
Ports (name, direction, width, meaning):
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 scan_en  input  1  level; 1 permits frames to start.
REQ-006 display_number  output  6  slot number requested from the display-content provider; 0 = no request.
REQ-007 display_valid  input  1  provider response: slot holds content.
REQ-008 display_name  input  40  provider response: 5 ASCII chars, MSB = first char.
REQ-009 display_value  input  32  provider response: value for slot.
REQ-010 out_valid  output  1  an entry is presented on out_*.
REQ-011 out_ready  input  1  downstream renderer accepts the entry.
REQ-012 out_index  output  6  slot number of the presented entry.
REQ-013 out_name  output  40  captured name.
REQ-014 out_value  output  32  captured value.
REQ-015 frame_done  output  1  one-cycle pulse after slot NUM_ENTRIES is processed.

Function
REQ-016 The provider registers its response on clk; data for display_number N is valid exactly 2 rising edges after display_number becomes N, and the block shall sample only at that point.
REQ-017 FSM states: IDLE, ADDR, SETTLE, EMIT, GAP.
REQ-018 IDLE: display_number=0; if scan_en=1, load slot=1, go ADDR.
REQ-019 ADDR (1 cycle): display_number=slot; go SETTLE.
REQ-020 SETTLE (1 cycle): display_number holds slot; at exit edge latch display_name/value into out_name/out_value and slot into out_index; go EMIT if display_valid=1, else advance.
REQ-021 EMIT: out_valid=1, out_* stable; on edge with out_ready=1, drop out_valid and advance; no stall limit.
REQ-022 Advance: if slot<NUM_ENTRIES, slot+1, go ADDR; else assert frame_done for the next cycle, go GAP.
REQ-023 GAP: count FRAME_GAP cycles (FRAME_GAP=0 means zero gap cycles), then go IDLE; display_number=0.
REQ-024 scan_en=0 is only sampled in IDLE; a frame in progress always completes.
REQ-025 out_valid shall be 0 in every state except EMIT; out_* hold last captured values outside EMIT.
REQ-026 Slot counter shall never wrap past NUM_ENTRIES nor take value 0 during a frame.
REQ-027 Throughput: a slot with display_valid=0 takes 2 cycles; a valid slot with out_ready held 1 takes 3 cycles.

Reset
REQ-028 While reset=1: state=IDLE, slot=0, display_number=0, out_valid=0, out_index=0, out_name=0, out_value=0, frame_done=0, gap counter=0.
REQ-029 Reset asserted mid-frame (including in EMIT) aborts the frame immediately; no frame_done is produced for it.
REQ-030 After reset deassertion the first frame starts from slot 1.

Configuration
REQ-031 Macro DISPLAY_SCAN_CHANGE_ONLY_EN: when defined, the block keeps per-slot shadow registers (valid bit, 40-bit name, 32-bit value), and a valid slot enters EMIT only if it was invalid in the previous frame or its name or value differs from the shadow; the shadow is updated at SETTLE exit for every slot (invalid slots clear the valid bit); reset clears all shadows.
REQ-032 When not defined, no shadow storage exists and every valid slot is emitted every frame.

Verification
REQ-033 Provider returns valid only for slots 1,2,3,5,6; scan_en=1, out_ready=1 -> exactly 5 entries per frame, out_index 1,2,3,5,6 in order, frame_done once per frame.
REQ-034 Slot 2 = ("WDATA", 0x12345678), out_ready held 0 for 10 cycles in EMIT -> out_valid and out_* stable 10 cycles; accepted on the 11th; display_number then 3.
REQ-035 Provider with exact 2-edge latency, unique value per slot (value=slot*0x11) -> every out_value equals out_index*0x11; no off-by-one.
REQ-036 reset pulsed while in EMIT for slot 5 -> out_valid=0 and display_number=0 asynchronously; next frame starts at slot 1, no frame_done from the aborted frame.
REQ-037 FRAME_GAP=16, provider all-invalid -> frame_done every 2*NUM_ENTRIES+1+16+1 = 106 cycles (NUM_ENTRIES=44), out_valid never 1.
REQ-038 With DISPLAY_SCAN_CHANGE_ONLY_EN: constant content -> entries emitted in frame 1 only; change slot 3 value 0->7 -> exactly one entry (index 3, value 7) in the next frame.
